// File: rtl/paging_unit.sv
// paging_unit
//   Z80 memory paging for the Spectrum core: 48K, 128K/+2 and +2A/+3 models,
//   extended RAM pages from 7FFD d[7:6], and a DivMMC overlay with automapper.
//
// Ports
//   clock, reset      : system clock, asynchronous active-high reset
//   ce                : CPU clock enable qualifying every state update
//   model[1:0]        : 0 = 48K, 1 = 128K/+2, 2/3 = +2A/+3
//   mapper            : DivMMC automapper enable
//   rfsh..m1          : Z80 strobes, active-low
//   a[15:0], d[7:0]   : CPU address / data out
//   va[12:0]          : video fetch address
//   cn                : access at a hits contended RAM
//   vmmA1 / vmmA2     : video read / video write addresses
//   vmmWr             : CPU write lands in the first 8K of page 5 or 7
//   memRf/memRd/memWr : SRAM strobes, active-high
//   memA[OW+1:0]      : {region, offset}; 00 ROM, 01 RAM, 10 DivMMC RAM
//   automapped        : DivMMC overlay currently active
module paging_unit #(
  parameter int RAM_PAGE_BITS = 3,
  parameter int DIV_PAGE_BITS = 4,
  parameter int OW = ((RAM_PAGE_BITS + 14) > (DIV_PAGE_BITS + 13))
                   ? (((RAM_PAGE_BITS + 14) > 17) ? (RAM_PAGE_BITS + 14) : 17)
                   : (((DIV_PAGE_BITS + 13) > 17) ? (DIV_PAGE_BITS + 13) : 17)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ce,
  input  logic [1:0]    model,
  input  logic          mapper,
  input  logic          rfsh,
  input  logic          mreq,
  input  logic          iorq,
  input  logic          rd,
  input  logic          wr,
  input  logic          m1,
  input  logic [15:0]   a,
  input  logic [7:0]    d,
  input  logic [12:0]   va,
  output logic          cn,
  output logic [13:0]   vmmA1,
  output logic [13:0]   vmmA2,
  output logic          vmmWr,
  output logic          memRf,
  output logic          memRd,
  output logic          memWr,
  output logic [OW+1:0] memA,
  output logic          automapped
);

  localparam int RPB = RAM_PAGE_BITS;
  localparam int DPB = DIV_PAGE_BITS;

  localparam logic [1:0] REG_ROM = 2'b00;
  localparam logic [1:0] REG_RAM = 2'b01;
  localparam logic [1:0] REG_DIV = 2'b10;

  typedef enum logic [1:0] {TGT_7FFD, TGT_1FFD, TGT_E3} tgt_e;
  typedef enum logic [1:0] {AM_OFF, AM_ARM_ON, AM_ON, AM_ARM_OFF} am_e;

  // +2A/+3 all-RAM configurations, indexed by 1FFD[2:1] and the 16K slot.
  function automatic logic [2:0] spec_page(input logic [1:0] mode,
                                           input logic [1:0] slot);
    logic [2:0] pg;
    case (mode)
      2'd0:    pg = {1'b0, slot};
      2'd1:    pg = {1'b1, slot};
      2'd2:    pg = (slot == 2'd3) ? 3'd3 : {1'b1, slot};
      default: case (slot)
                 2'd0:    pg = 3'd4;
                 2'd1:    pg = 3'd7;
                 2'd2:    pg = 3'd6;
                 default: pg = 3'd3;
               endcase
    endcase
    return pg;
  endfunction

  logic [7:0]     p7ffd_q, p7ffd_d;
  logic [2:0]     p1ffd_q, p1ffd_d;
  logic           lock_q, lock_d;
  logic           conmem_q, conmem_d;
  logic           mapram_q, mapram_d;
  logic [DPB-1:0] bank_q, bank_d;
  logic           pend_vld_q, pend_vld_d;
  tgt_e           pend_tgt_q, pend_tgt_d;
  logic [7:0]     pend_dat_q, pend_dat_d;
  logic           iowr_q, iowr_d;
  logic           fetch_q, fetch_d;
  am_e            am_q, am_d;

  logic io_wr, is_7ffd, is_1ffd, is_e3;
  logic fetch, fetch_first, am_entry, am_3d, am_exit;

  assign io_wr   = !iorq && !wr;
  assign is_7ffd = (model == 2'd1) ? (!a[15] && !a[1])
                                   : (model[1] && (a[15:14] == 2'b01) && !a[1]);
  assign is_1ffd = model[1] && (a[15:12] == 4'b0001) && !a[1];
  assign is_e3   = (a[7:0] == 8'hE3);

  assign fetch       = !mreq && !m1;
  assign fetch_first = fetch && !fetch_q;
  assign am_entry    = (a == 16'h0000) || (a == 16'h0008) || (a == 16'h0038) ||
                       (a == 16'h0066) || (a == 16'h04C6) || (a == 16'h0562);
  assign am_3d       = (a[15:8] == 8'h3D);
  assign am_exit     = (a[15:3] == 13'h03FF);

  // Port capture / commit and the automapper share one next-state process.
  always_comb begin
    p7ffd_d    = p7ffd_q;
    p1ffd_d    = p1ffd_q;
    lock_d     = lock_q;
    conmem_d   = conmem_q;
    mapram_d   = mapram_q;
    bank_d     = bank_q;
    pend_vld_d = pend_vld_q;
    pend_tgt_d = pend_tgt_q;
    pend_dat_d = pend_dat_q;
    iowr_d     = iowr_q;
    fetch_d    = fetch_q;
    am_d       = am_q;
    if (ce) begin
      iowr_d     = io_wr;
      fetch_d    = fetch;
      pend_vld_d = 1'b0;
      // Commit happens before a same-cycle capture so back-to-back writes
      // land in order, one cycle apart.
      if (pend_vld_q) begin
        case (pend_tgt_q)
          TGT_7FFD: if (!lock_q) begin
                      p7ffd_d = pend_dat_q;
                      lock_d  = pend_dat_q[5];
                    end
          TGT_1FFD: if (!lock_q) p1ffd_d = pend_dat_q[2:0];
          default:  begin
                      conmem_d = pend_dat_q[7];
                      bank_d   = pend_dat_q[DPB-1:0];
                      mapram_d = mapram_q | pend_dat_q[6];
                    end
        endcase
      end
      // Edge detect on the strobe: a held wr yields a single capture.
      if (io_wr && !iowr_q && (is_7ffd || is_1ffd || is_e3)) begin
        pend_vld_d = 1'b1;
        pend_dat_d = d;
        if (is_e3)        pend_tgt_d = TGT_E3;
        else if (is_1ffd) pend_tgt_d = TGT_1FFD;
        else              pend_tgt_d = TGT_7FFD;
      end
      if (fetch_first) begin
        if (am_3d)                          am_d = AM_ON;
        else if (am_entry)                  am_d = AM_ARM_ON;
        else if (am_exit && am_q == AM_ON)  am_d = AM_ARM_OFF;
      end else if (m1) begin
        if (am_q == AM_ARM_ON)       am_d = AM_ON;
        else if (am_q == AM_ARM_OFF) am_d = AM_OFF;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      p7ffd_q    <= '0;
      p1ffd_q    <= '0;
      lock_q     <= 1'b0;
      conmem_q   <= 1'b0;
      mapram_q   <= 1'b0;
      bank_q     <= '0;
      pend_vld_q <= 1'b0;
      pend_tgt_q <= TGT_7FFD;
      pend_dat_q <= '0;
      iowr_q     <= 1'b0;
      fetch_q    <= 1'b0;
      am_q       <= AM_OFF;
    end else begin
      p7ffd_q    <= p7ffd_d;
      p1ffd_q    <= p1ffd_d;
      lock_q     <= lock_d;
      conmem_q   <= conmem_d;
      mapram_q   <= mapram_d;
      bank_q     <= bank_d;
      pend_vld_q <= pend_vld_d;
      pend_tgt_q <= pend_tgt_d;
      pend_dat_q <= pend_dat_d;
      iowr_q     <= iowr_d;
      fetch_q    <= fetch_d;
      am_q       <= am_d;
    end
  end

  logic           special, ovl, ram_sel, wr_ok, page_low8, contended, shadow;
  logic [RPB-1:0] page, page_c000;
  logic [2:0]     rom_slot;
  logic [1:0]     region;
  logic [OW-1:0]  off;
  logic [6:0]     lo7;

  assign special   = model[1] && p1ffd_q[0];
  // The 3Dxx trap maps in on the very fetch that triggers it.
  assign ovl       = conmem_q ||
                     (mapper && (am_q == AM_ON || am_q == AM_ARM_OFF || (fetch && am_3d)));
  assign page_c000 = (model == 2'd0) ? '0 : RPB'({p7ffd_q[7:6], p7ffd_q[2:0]});
  assign rom_slot  = (model == 2'd0) ? 3'd0 :
                     (model == 2'd1) ? {2'b01, p7ffd_q[4]} :
                                       {1'b0, p1ffd_q[2], p7ffd_q[4]};

  always_comb begin
    region  = REG_ROM;
    off     = '0;
    page    = '0;
    ram_sel = 1'b0;
    if (special) begin
      ram_sel = 1'b1;
      page    = RPB'(spec_page(p1ffd_q[2:1], a[15:14]));
    end else begin
      case (a[15:14])
        2'd1:    begin ram_sel = 1'b1; page = RPB'(5); end
        2'd2:    begin ram_sel = 1'b1; page = RPB'(2); end
        2'd3:    begin ram_sel = 1'b1; page = page_c000; end
        default: ram_sel = 1'b0;
      endcase
    end
    if (ram_sel) begin
      region = REG_RAM;
      off    = OW'({page, a[13:0]});
    end else begin
      off    = OW'({rom_slot, a[13:0]});
    end
    if (ovl && a[15:14] == 2'b00) begin
      ram_sel = 1'b0;
      if (a[13]) begin
        region = REG_DIV;
        off    = OW'({bank_q, a[12:0]});
      end else if (mapram_q) begin
        region = REG_DIV;
        off    = OW'({DPB'(3), a[12:0]});
      end else begin
        region = REG_ROM;
        off    = OW'({3'd4, 1'b0, a[12:0]});
      end
    end
  end

  // Overlay 0000-1FFF is never writable, and with mapram bank 3 stands in
  // for the esx ROM so it is read-only at 2000 as well.
  assign wr_ok = (region == REG_RAM) ||
                 ((region == REG_DIV) && a[13] && !(mapram_q && bank_q == DPB'(3)));

  assign memA  = {region, off};
  assign memRd = !mreq && !rd;
  assign memWr = !mreq && !wr && wr_ok;
  assign memRf = !mreq && !rfsh;

  assign page_low8 = ((page >> 3) == '0);
  assign contended = model[1] ? (page_low8 && page[2]) : (page_low8 && page[0]);
  assign cn        = ram_sel && contended;

  assign shadow     = (model != 2'd0) && p7ffd_q[3];
  // During refresh the address bus leaks into the video low bits (snow).
  assign lo7        = (!rfsh && a[15:14] == 2'b01) ? a[6:0] : va[6:0];
  assign vmmA1      = {shadow, va[12:7], lo7};
  assign vmmA2      = {ram_sel && (page == RPB'(7)), a[12:0]};
  assign vmmWr      = memWr && ram_sel && !a[13] && (page == RPB'(5) || page == RPB'(7));
  assign automapped = ovl;

endmodule

// File: tb/tb_paging_unit.sv
module tb_paging_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ce = 1'b1;
  logic [1:0]  model = 2'd0;
  logic        mapper = 1'b0;
  logic        rfsh = 1'b1, mreq = 1'b1, iorq = 1'b1, rd = 1'b1, wr = 1'b1, m1 = 1'b1;
  logic [15:0] a = 16'h0000;
  logic [7:0]  d = 8'h00;
  logic [12:0] va = 13'h1234;

  logic        cn, vmmWr, memRf, memRd, memWr, automapped;
  logic [13:0] vmmA1, vmmA2;
  logic [18:0] memA;
  logic        cn5, vmmWr5, memRf5, memRd5, memWr5, automapped5;
  logic [13:0] vmmA1_5, vmmA2_5;
  logic [20:0] memA5;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  paging_unit dut (
    .clock(clock), .reset(reset), .ce(ce), .model(model), .mapper(mapper),
    .rfsh(rfsh), .mreq(mreq), .iorq(iorq), .rd(rd), .wr(wr), .m1(m1),
    .a(a), .d(d), .va(va), .cn(cn), .vmmA1(vmmA1), .vmmA2(vmmA2),
    .vmmWr(vmmWr), .memRf(memRf), .memRd(memRd), .memWr(memWr),
    .memA(memA), .automapped(automapped)
  );

  paging_unit #(.RAM_PAGE_BITS(5)) dut5 (
    .clock(clock), .reset(reset), .ce(ce), .model(model), .mapper(mapper),
    .rfsh(rfsh), .mreq(mreq), .iorq(iorq), .rd(rd), .wr(wr), .m1(m1),
    .a(a), .d(d), .va(va), .cn(cn5), .vmmA1(vmmA1_5), .vmmA2(vmmA2_5),
    .vmmWr(vmmWr5), .memRf(memRf5), .memRd(memRd5), .memWr(memWr5),
    .memA(memA5), .automapped(automapped5)
  );

  always #5 clock = ~clock;

  // Expected memA values, 17-bit offset unless noted.
  function automatic logic [31:0] ram_e(input int pg, input logic [15:0] ad);
    return 32'(131072 + pg * 16384 + int'(ad[13:0]));
  endfunction
  function automatic logic [31:0] ram5_e(input int pg, input logic [15:0] ad);
    return 32'(524288 + pg * 16384 + int'(ad[13:0]));
  endfunction
  function automatic logic [31:0] rom_e(input int slot, input logic [15:0] ad);
    return 32'(slot * 16384 + int'(ad[13:0]));
  endfunction
  function automatic logic [31:0] esx_e(input logic [15:0] ad);
    return 32'(65536 + int'(ad[12:0]));
  endfunction
  function automatic logic [31:0] div_e(input int bank, input logic [15:0] ad);
    return 32'(262144 + bank * 8192 + int'(ad[12:0]));
  endfunction

  task automatic expect_v(input string tag, input logic [31:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic observe(input logic [31:0] obs);
    logic [31:0] e;
    string t;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%0h required=none", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s observed=%0h required=%0h", t, obs, e);
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    mreq = 1'b1; iorq = 1'b1; rd = 1'b1; wr = 1'b1; m1 = 1'b1; rfsh = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic io_write(input logic [15:0] port, input logic [7:0] val, input int hold);
    a = port; d = val; iorq = 1'b0; wr = 1'b0;
    for (int i = 0; i < hold; i++) tick();
    iorq = 1'b1; wr = 1'b1;
    tick();
  endtask

  task automatic rd_chk(input string tag, input logic [15:0] ad, input logic [31:0] e);
    a = ad; mreq = 1'b0; rd = 1'b0;
    expect_v(tag, e);
    #2;
    observe(32'(memA));
    idle();
  endtask

  task automatic wr_chk(input string tag, input logic [15:0] ad, input logic e);
    a = ad; mreq = 1'b0; wr = 1'b0;
    expect_v(tag, 32'(e));
    #2;
    observe(32'(memWr));
    idle();
  endtask

  task automatic fetch_chk(input string tag, input logic [15:0] ad, input logic [31:0] e);
    a = ad; mreq = 1'b0; m1 = 1'b0; rd = 1'b0;
    expect_v(tag, e);
    #2;
    observe(32'(memA));
    tick();
    idle();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Reset state, 128K model
    model = 2'd1;
    rd_chk("rst_c000", 16'hC000, ram_e(0, 16'hC000));
    rd_chk("rst_rom", 16'h0000, rom_e(2, 16'h0000));
    expect_v("rst_automapped", 32'd0); observe(32'(automapped));

    // 7FFD=0x17: old mapping during the pending cycle, new one after
    a = 16'h7FFD; d = 8'h17; iorq = 1'b0; wr = 1'b0;
    tick();
    iorq = 1'b1; wr = 1'b1;
    rd_chk("pending_old_map", 16'hC000, ram_e(0, 16'hC000));
    tick();
    rd_chk("c000_page7", 16'hC000, ram_e(7, 16'hC000));
    rd_chk("rom_slot3", 16'h0000, rom_e(3, 16'h0000));
    a = 16'hC000; expect_v("cn_c000", 32'd1); #1; observe(32'(cn));
    expect_v("shadow0", 32'h1234); #1; observe(32'(vmmA1));

    // Long strobe, shadow screen and video write path
    io_write(16'h7FFD, 8'h0F, 3);
    expect_v("shadow1", 32'h3234); #1; observe(32'(vmmA1));
    a = 16'hC010; mreq = 1'b0; wr = 1'b0;
    expect_v("vmmwr_p7", 32'd1); #1; observe(32'(vmmWr));
    expect_v("vmma2_p7", 32'h2010); #1; observe(32'(vmmA2));
    idle();
    a = 16'h4005; mreq = 1'b0; rfsh = 1'b0;
    expect_v("snow_lo7", 32'h3205); #1; observe(32'(vmmA1));
    expect_v("memrf", 32'd1); #1; observe(32'(memRf));
    idle();
    a = 16'h6000; mreq = 1'b0; wr = 1'b0;
    expect_v("vmmwr_upper8k", 32'd0); #1; observe(32'(vmmWr));
    idle();

    // Lock
    io_write(16'h7FFD, 8'h20, 1);
    rd_chk("lock_p0", 16'hC000, ram_e(0, 16'hC000));
    io_write(16'h7FFD, 8'h03, 1);
    rd_chk("locked", 16'hC000, ram_e(0, 16'hC000));
    io_write(16'h00E3, 8'h80, 1);
    rd_chk("e3_not_locked", 16'h0000, esx_e(16'h0000));
    io_write(16'h00E3, 8'h00, 1);
    do_reset();
    io_write(16'h7FFD, 8'h03, 1);
    rd_chk("unlocked", 16'hC000, ram_e(3, 16'hC000));

    // +2A special paging
    do_reset();
    model = 2'd2;
    io_write(16'h1FFD, 8'h03, 1);
    rd_chk("sp1_0000", 16'h0000, ram_e(4, 16'h0000));
    rd_chk("sp1_4000", 16'h4000, ram_e(5, 16'h4000));
    rd_chk("sp1_8000", 16'h8000, ram_e(6, 16'h8000));
    rd_chk("sp1_c000", 16'hC000, ram_e(7, 16'hC000));
    wr_chk("sp1_wr0000", 16'h0000, 1'b1);
    a = 16'h0000; expect_v("sp1_cn", 32'd1); #1; observe(32'(cn));
    io_write(16'h1FFD, 8'h05, 1);
    rd_chk("sp2_c000", 16'hC000, ram_e(3, 16'hC000));
    a = 16'hC000; expect_v("sp2_cn", 32'd0); #1; observe(32'(cn));
    io_write(16'h1FFD, 8'h04, 1);
    io_write(16'h7FFD, 8'h10, 1);
    rd_chk("p2a_rom3", 16'h0000, rom_e(3, 16'h0000));
    wr_chk("rom_wr_drop", 16'h0000, 1'b0);

    // Automapper
    do_reset();
    model = 2'd0; mapper = 1'b1;
    fetch_chk("am_0038", 16'h0038, rom_e(0, 16'h0038));
    fetch_chk("am_0039", 16'h0039, esx_e(16'h0039));
    expect_v("am_on", 32'd1); observe(32'(automapped));
    fetch_chk("am_1ff8", 16'h1FF8, esx_e(16'h1FF8));
    expect_v("am_off", 32'd0); observe(32'(automapped));
    fetch_chk("am_0050", 16'h0050, rom_e(0, 16'h0050));
    fetch_chk("am_3d00", 16'h3D00, div_e(0, 16'h3D00));
    expect_v("am_3d_on", 32'd1); observe(32'(automapped));
    mapper = 1'b0;
    expect_v("am_mapper_off", 32'd0); #1; observe(32'(automapped));

    // DivMMC port, mapram and write protection
    do_reset();
    io_write(16'h00E3, 8'h43, 1);
    rd_chk("e3_noconmem", 16'h0000, rom_e(0, 16'h0000));
    io_write(16'h00E3, 8'h00, 1);
    io_write(16'h00E3, 8'h80, 1);
    rd_chk("mapram_sticky", 16'h0000, div_e(3, 16'h0000));
    wr_chk("div_wr_bank0", 16'h2000, 1'b1);
    io_write(16'h00E3, 8'h83, 1);
    wr_chk("div_wr_bank3", 16'h2000, 1'b0);
    rd_chk("div_rd_bank3", 16'h2000, div_e(3, 16'h2000));
    wr_chk("div_wr_0000", 16'h0000, 1'b0);

    // Extended RAM pages
    do_reset();
    model = 2'd1;
    io_write(16'h7FFD, 8'hC1, 1);
    rd_chk("rpb3_c000", 16'hC000, ram_e(1, 16'hC000));
    a = 16'hC000; mreq = 1'b0; rd = 1'b0;
    expect_v("rpb5_c000", ram5_e(25, 16'hC000)); #1; observe(32'(memA5));
    idle();

    // Reset with a commit pending
    a = 16'h7FFD; d = 8'h07; iorq = 1'b0; wr = 1'b0;
    tick();
    reset = 1'b1; iorq = 1'b1; wr = 1'b1;
    #2;
    reset = 1'b0;
    tick();
    tick();
    rd_chk("rstpend_c000", 16'hC000, ram_e(0, 16'hC000));
    rd_chk("rstpend_rom", 16'h0000, rom_e(2, 16'h0000));
    a = 16'hC000; mreq = 1'b0; rd = 1'b0;
    expect_v("rstpend_rpb5", ram5_e(0, 16'hC000)); #1; observe(32'(memA5));
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
